// File: rtl/mmm_serial_datapath.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One iteration per enabled clock, then one conditional-subtract cycle.
module mmm_serial_datapath #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             rst_mmm,
   input  logic             ld_a,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned AccW = WIDTH + 2;

   typedef enum logic [1:0] {StIdle, StIter, StCorrect, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_sr_q, a_sr_d;
   logic [WIDTH-1:0]  b_reg_q, b_reg_d;
   logic [WIDTH-1:0]  m_reg_q, m_reg_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              done_q, done_d;
   logic [AccW-1:0]   t_sum, q_sum, diff;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_reg_q  <= '0;
         m_reg_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_reg_q  <= b_reg_d;
         m_reg_q  <= m_reg_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_reg_d  = b_reg_q;
      m_reg_d  = m_reg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = done_q;
      t_sum    = '0;
      q_sum    = '0;
      diff     = '0;
      if (!rst_mmm) begin
         state_d  = StIdle;
         a_sr_d   = '0;
         b_reg_d  = '0;
         m_reg_d  = '0;
         acc_d    = '0;
         cnt_d    = '0;
         result_d = '0;
         done_d   = 1'b0;
      end else if (ld_a) begin
         state_d = StIter;
         a_sr_d  = a_in;
         b_reg_d = b_in;
         m_reg_d = m_in;
         acc_d   = '0;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            StIter: begin
               // acc stays below 2M, so the WIDTH+2 bit sums never overflow
               t_sum  = acc_q + (a_sr_q[0] ? {2'b00, b_reg_q} : '0);
               q_sum  = t_sum + (t_sum[0] ? {2'b00, m_reg_q} : '0);
               acc_d  = q_sum >> 1;
               a_sr_d = a_sr_q >> 1;
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  state_d = StCorrect;
               end
            end
            StCorrect: begin
               diff     = acc_q - {2'b00, m_reg_q};
               result_d = (acc_q >= {2'b00, m_reg_q}) ? diff[WIDTH-1:0] : acc_q[WIDTH-1:0];
               done_d   = 1'b1;
               state_d  = StDone;
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = (state_q == StIter) || (state_q == StCorrect);

endmodule

// File: tb/tb_mmm_serial_datapath.sv
// Scoreboard bench for mmm_serial_datapath: the driver queues expected products,
// the monitor checks result and enabled-edge latency whenever done rises.
module tb_mmm_serial_datapath;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rstb;
   logic             ena;
   logic             rst_mmm;
   logic             ld_a;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] m_in;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             busy;

   int tests  = 0;
   int fails  = 0;
   int edges  = 0;
   logic done_prev = 1'b0;
   int exp_q[$];

   mmm_serial_datapath #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rstb    (rstb),
      .ena     (ena),
      .rst_mmm (rst_mmm),
      .ld_a    (ld_a),
      .a_in    (a_in),
      .b_in    (b_in),
      .m_in    (m_in),
      .result  (result),
      .done    (done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Count enabled, non-clearing edges since the last load edge
   always @(posedge clk) begin
      if (!rstb || (ena && !rst_mmm)) edges <= 0;
      else if (ena && ld_a) edges <= 0;
      else if (ena) edges <= edges + 1;
   end

   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            int e;
            e = exp_q.pop_front();
            check("result", int'(result), e);
            check("latency", edges, 9);
         end
      end
      done_prev = done;
   end

   task automatic load(input int a, input int b, input int m);
      ld_a = 1'b1;
      a_in = WIDTH'(a);
      b_in = WIDTH'(b);
      m_in = WIDTH'(m);
      @(negedge clk);
      ld_a = 1'b0;
      a_in = '0;
      b_in = '0;
      m_in = '0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", int'(done), 1);
   endtask

   task automatic check_idle(input string name);
      check({name, "_result"}, int'(result), 0);
      check({name, "_done"}, int'(done), 0);
      check({name, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      rstb = 1'b0; ena = 1'b1; rst_mmm = 1'b1; ld_a = 1'b0;
      a_in = '0; b_in = '0; m_in = '0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rstb = 1'b1;
      @(negedge clk);
      check_idle("idle");

      // 5*7 mod 13: busy for exactly 9 edges, then result holds
      load(5, 7, 13);
      exp_q.push_back(1);
      for (int i = 0; i < 9; i++) begin
         check("busy_run", int'(busy), 1);
         check("done_run", int'(done), 0);
         @(negedge clk);
      end
      check("done_after9", int'(done), 1);
      check("busy_after9", int'(busy), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold", int'({done, busy, result}), int'({1'b1, 1'b0, 8'd1}));
      end

      load(12, 12, 13);
      exp_q.push_back(3);
      wait_done(30);
      load(254, 254, 255);
      exp_q.push_back(1);
      wait_done(30);

      // Held load: no iteration while ld_a stays high
      ld_a = 1'b1; a_in = 8'd0; b_in = 8'd200; m_in = 8'd201;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_busy", int'(busy), 1);
         check("held_done", int'(done), 0);
      end
      ld_a = 1'b0;
      exp_q.push_back(0);
      wait_done(30);

      // Restart mid-run: only the second operation may complete
      load(5, 7, 13);
      repeat (4) @(negedge clk);
      load(12, 12, 13);
      exp_q.push_back(3);
      wait_done(30);

      // Clear mid-run
      load(5, 7, 13);
      repeat (3) @(negedge clk);
      rst_mmm = 1'b0;
      @(negedge clk);
      rst_mmm = 1'b1;
      check_idle("rst_mmm");
      repeat (12) @(negedge clk);
      check("rst_mmm_stays", int'(done), 0);

      // Random stalls must not change the result or enabled-edge latency
      load(5, 7, 13);
      exp_q.push_back(1);
      for (int n = 0; n < 200 && !done; n++) begin
         ena = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      ena = 1'b1;
      check("ena_done_seen", int'(done), 1);

      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      check_idle("rstb_done");

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
